// File: rtl/huffman_enc.sv
// huffman_enc: streaming prefix-code decoder. Unpacks W-bit words of MSB-first
// Huffman codes into W-bit symbols, at most one symbol per clock, using a
// runtime-loaded table of (code, width, symbol) entries.
// Optional feature macro: HUFF_ERR_EN adds err_out, a registered one-cycle
// pulse for every bit dropped as part of an invalid code.
module huffman_enc #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    output logic         d_req,
    input  logic [W-1:0] d_in,
    input  logic         en_in,
    input  logic         ready_in,
    input  logic [W-1:0] d_conf,
    input  logic [W-1:0] h_conf,
    input  logic [W-1:0] w_conf,
    input  logic         en_conf,
    input  logic         new_conf,
    output logic [W-1:0] d_out,
    output logic         en_out
`ifdef HUFF_ERR_EN
    ,
    output logic         err_out
`endif
);

    localparam int FW = $clog2(2*W + 1);   // fill counter width, 0..2W
    localparam int WW = $clog2(W + 1);     // stored code width, 1..W
    localparam int IW = $clog2(DEPTH);     // table index
    localparam int PW = $clog2(DEPTH + 1); // write pointer, 0..DEPTH

    localparam logic [FW-1:0] FILL_W   = FW'(W);
    localparam logic [FW-1:0] FILL_2W  = FW'(2*W);
    localparam logic [W-1:0]  W_MAX    = W'(W);
    localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

    logic [W-1:0]   tbl_sym  [DEPTH];
    logic [W-1:0]   tbl_code [DEPTH];
    logic [WW-1:0]  tbl_w    [DEPTH];
    logic [DEPTH-1:0] tbl_vld;
    logic [PW-1:0]  wr_ptr;

    logic [2*W-1:0] bit_buf;
    logic [FW-1:0]  fill;

    logic           cfg_ok;
    logic [DEPTH-1:0] match;
    logic           hit;
    logic [IW-1:0]  hit_idx;
    logic           drop;
    logic           app;
    logic [FW-1:0]  cons;
    logic [FW-1:0]  fill_mid;
    logic [FW-1:0]  fill_nxt;
    logic [2*W-1:0] buf_nxt;

    // Accept a table write only when it has room and a legal width; a clear wins.
    assign cfg_ok = en_conf && !new_conf && (wr_ptr < PTR_FULL)
                    && (w_conf != '0) && (w_conf <= W_MAX);

    // Table bookkeeping: valid flags and write pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tbl_vld <= '0;
            wr_ptr  <= '0;
        end else if (new_conf) begin
            tbl_vld <= '0;
            wr_ptr  <= '0;
        end else if (cfg_ok) begin
            tbl_vld[wr_ptr[IW-1:0]] <= 1'b1;
            wr_ptr                  <= wr_ptr + PW'(1);
        end
    end

    // Table payload; contents are don't-care until the valid flag is set.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            tbl_sym[wr_ptr[IW-1:0]]  <= d_conf;
            tbl_code[wr_ptr[IW-1:0]] <= h_conf;
            tbl_w[wr_ptr[IW-1:0]]    <= w_conf[WW-1:0];
        end
    end

    // Per-entry compare of the top w_k buffer bits against the masked code.
    always_comb begin
        match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = tbl_vld[k]
                && (fill >= FW'(tbl_w[k]))
                && ((((W'(bit_buf >> (FILL_2W - FW'(tbl_w[k])))) ^ tbl_code[k])
                     & ((W'(1) << tbl_w[k]) - W'(1))) == '0);
        end
    end

    // Lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit     = 1'b1;
                hit_idx = IW'(k);
            end
        end
    end

    // Consume (match or invalid-bit drop) first, then append the new word behind
    // the remaining valid bits. Bits below fill are kept zero so OR-append works.
    always_comb begin
        drop     = !hit && (fill >= FILL_W);
        cons     = hit ? FW'(tbl_w[hit_idx]) : (drop ? FW'(1) : '0);
        fill_mid = fill - cons;
        app      = en_in && (fill <= FILL_W);
        buf_nxt  = (bit_buf << cons)
                   | (app ? ({d_in, {W{1'b0}}} >> fill_mid) : '0);
        fill_nxt = fill_mid + (app ? FILL_W : '0);
    end

    // Buffer, request and output registers; a table clear also flushes the buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_buf <= '0;
            fill    <= '0;
            d_req   <= 1'b0;
            en_out  <= 1'b0;
            d_out   <= '0;
`ifdef HUFF_ERR_EN
            err_out <= 1'b0;
`endif
        end else begin
            if (new_conf) begin
                bit_buf <= '0;
                fill    <= '0;
                d_req   <= ready_in;
            end else begin
                bit_buf <= buf_nxt;
                fill    <= fill_nxt;
                d_req   <= ready_in && (fill_nxt <= FILL_W);
            end
            en_out <= hit && !new_conf;
            if (hit && !new_conf) begin
                d_out <= tbl_sym[hit_idx];
            end
`ifdef HUFF_ERR_EN
            err_out <= drop && !new_conf;
`endif
        end
    end

endmodule

// File: tb/tb_huffman_enc.sv
// tb_huffman_enc: scoreboard bench for huffman_enc. A bit-queue reference
// decoder predicts symbols as words are driven; a monitor pops and compares.
module tb_huffman_enc;

    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         d_req;
    logic [W-1:0] d_in = '0;
    logic         en_in = 1'b0;
    logic         ready_in = 1'b1;
    logic [W-1:0] d_conf = '0;
    logic [W-1:0] h_conf = '0;
    logic [W-1:0] w_conf = '0;
    logic         en_conf = 1'b0;
    logic         new_conf = 1'b0;
    logic [W-1:0] d_out;
    logic         en_out;
`ifdef HUFF_ERR_EN
    logic         err_out;
`endif

    huffman_enc #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_req    (d_req),
        .d_in     (d_in),
        .en_in    (en_in),
        .ready_in (ready_in),
        .d_conf   (d_conf),
        .h_conf   (h_conf),
        .w_conf   (w_conf),
        .en_conf  (en_conf),
        .new_conf (new_conf),
        .d_out    (d_out),
        .en_out   (en_out)
`ifdef HUFF_ERR_EN
        ,
        .err_out  (err_out)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int got_err  = 0;
    int exp_err  = 0;
    bit rand_ready = 1'b0;

    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    // reference model state
    bit         m_bits [$];
    logic [7:0] m_code [$];
    logic [7:0] m_sym  [$];
    int         m_w    [$];

    logic [7:0] t_sym  [5] = '{8'h11, 8'h33, 8'h66, 8'h77, 8'h88};
    logic [7:0] t_code [5] = '{8'b10, 8'b01, 8'b110011, 8'b1100011, 8'b11000011};
    int         t_w    [5] = '{2, 2, 6, 7, 8};

    function automatic void chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Decode as far as the pending bits allow: emit on a prefix match, drop one
    // bit when a full word's worth of bits matches nothing, otherwise wait.
    function automatic void model_decode(input bit push);
        forever begin
            int hit;
            hit = -1;
            for (int k = 0; k < m_w.size(); k++) begin
                if (hit < 0 && m_w[k] <= m_bits.size()) begin
                    bit same;
                    logic [7:0] c;
                    same = 1'b1;
                    c = m_code[k];
                    for (int b = 0; b < m_w[k]; b++)
                        if (m_bits[b] != c[m_w[k]-1-b]) same = 1'b0;
                    if (same) hit = k;
                end
            end
            if (hit >= 0) begin
                if (push) exp_q.push_back(m_sym[hit]);
                repeat (m_w[hit]) void'(m_bits.pop_front());
            end else if (m_bits.size() >= W) begin
                void'(m_bits.pop_front());
                exp_err++;
            end else begin
                break;
            end
        end
    endfunction

    function automatic void model_word(input logic [7:0] w, input bit push);
        for (int b = 7; b >= 0; b--) m_bits.push_back(w[b]);
        model_decode(push);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_clear();
        new_conf = 1'b1;
        tick();
        new_conf = 1'b0;
        m_bits.delete();
        m_code.delete();
        m_sym.delete();
        m_w.delete();
    endtask

    task automatic cfg_add(input logic [7:0] sym, input logic [7:0] code, input int w);
        d_conf  = sym;
        h_conf  = code;
        w_conf  = 8'(w);
        en_conf = 1'b1;
        tick();
        en_conf = 1'b0;
        if (m_w.size() < DEPTH && w >= 1 && w <= W) begin
            m_sym.push_back(sym);
            m_code.push_back(code);
            m_w.push_back(w);
        end
    endtask

    task automatic load_main();
        for (int i = 0; i < 5; i++) cfg_add(t_sym[i], t_code[i], t_w[i]);
    endtask

    // Drive one word in the cycle after d_req is seen high.
    task automatic feed(input logic [7:0] w, input bit push);
        int budget;
        budget = 0;
        while (!d_req && budget < 200) begin
            ready_in = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            budget++;
        end
        if (!d_req) begin
            chk(1'b0, "d_req_timeout", 0, 1);
            return;
        end
        en_in = 1'b1;
        d_in  = w;
        model_word(w, push);
        tick();
        en_in = 1'b0;
        if (rand_ready) ready_in = ($urandom_range(0, 3) != 0);
    endtask

    task automatic feed_bits(input bit s [$]);
        bit q [$];
        logic [7:0] w;
        q = s;
        while (q.size() % 8 != 0) q.push_back(1'($urandom_range(0, 1)));
        while (q.size() > 0) begin
            for (int b = 7; b >= 0; b--) w[b] = q.pop_front();
            feed(w, 1'b1);
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            tick();
            budget++;
        end
        chk(exp_q.size() == 0, name, exp_q.size(), 0);
        repeat (16) tick();
`ifdef HUFF_ERR_EN
        chk(got_err == exp_err, {name, "_err_count"}, got_err, exp_err);
`endif
    endtask

    // Monitor: every en_out pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst && en_out) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_en_out", int'(d_out), -1);
            end else begin
                mon_exp = exp_q.pop_front();
                chk(d_out == mon_exp, "d_out", int'(d_out), int'(mon_exp));
            end
        end
`ifdef HUFF_ERR_EN
        if (rst && err_out) got_err++;
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int base;
        bit s [$];

        // reset values, with ready_in high to show d_req is still held low
        rst = 1'b0;
        ready_in = 1'b1;
        repeat (3) tick();
        chk(en_out == 1'b0, "reset_en_out", int'(en_out), 0);
        chk(d_out == 8'h00, "reset_d_out", int'(d_out), 0);
        chk(d_req == 1'b0, "reset_d_req", int'(d_req), 0);

        // ready_in low with an empty buffer: no request, no output
        ready_in = 1'b0;
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (d_req) bad++;
        end
        chk(bad == 0, "idle_d_req_cycles", bad, 0);
        ready_in = 1'b1;

        // reference stream, expectations written out directly
        load_main();
        exp_q.push_back(8'h11); exp_q.push_back(8'h33); exp_q.push_back(8'h66);
        exp_q.push_back(8'h77); exp_q.push_back(8'h88); exp_q.push_back(8'h77);
        base = n_out;
        feed(8'h9C, 1'b0);
        feed(8'hF1, 1'b0);
        feed(8'hE1, 1'b0);
        feed(8'hE3, 1'b0);
        drain("s1_drain");
        chk(n_out - base == 6, "s1_symbol_count", n_out - base, 6);

        // all-zero word is an invalid code: bits dropped, nothing emitted
        base = n_out;
        feed(8'h00, 1'b1);
        drain("s3_drain");
        chk(n_out == base, "s3_no_output", n_out - base, 0);

        // clear with a partial code buffered, reload a one-entry table
        cfg_clear();
        load_main();
        feed(8'h9C, 1'b1);
        drain("s4a_drain");
        cfg_clear();
        cfg_add(8'hEE, 8'h00, 0);
        cfg_add(8'h11, 8'h02, 2);
        cfg_add(8'hEF, 8'h00, 9);
        base = n_out;
        feed(8'hAA, 1'b1);
        drain("s4b_drain");
        chk(n_out - base == 4, "s4_symbol_count", n_out - base, 4);

        // randomized stream with occasional garbage bits and random ready_in
        cfg_clear();
        load_main();
        rand_ready = 1'b1;
        s.delete();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                int n;
                n = $urandom_range(1, 3);
                for (int b = 0; b < n; b++) s.push_back(1'($urandom_range(0, 1)));
            end else begin
                int j;
                logic [7:0] c;
                j = $urandom_range(0, 4);
                c = t_code[j];
                for (int b = t_w[j] - 1; b >= 0; b--) s.push_back(c[b]);
            end
        end
        feed_bits(s);
        drain("rand_drain");

        // overfilled table: the extra entry must not take effect
        cfg_clear();
        for (int i = 0; i < DEPTH; i++) cfg_add(8'(8'hA0 + i), 8'(8'h10 | i), 5);
        cfg_add(8'hEE, 8'h00, 1);
        s.delete();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                s.push_back(1'b0);
            end else begin
                logic [3:0] v;
                v = 4'($urandom_range(0, 15));
                s.push_back(1'b1);
                for (int b = 3; b >= 0; b--) s.push_back(v[b]);
            end
        end
        feed_bits(s);
        drain("full_table_drain");
        rand_ready = 1'b0;
        ready_in = 1'b1;

        // reset in the middle of decoding
        cfg_clear();
        load_main();
        feed(8'h9C, 1'b1);
        feed(8'hF1, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        chk(en_out == 1'b0, "midreset_en_out", int'(en_out), 0);
        chk(d_out == 8'h00, "midreset_d_out", int'(d_out), 0);
        chk(d_req == 1'b0, "midreset_d_req", int'(d_req), 0);
        exp_q.delete();
        m_bits.delete();
        m_code.delete();
        m_sym.delete();
        m_w.delete();
        exp_err = 0;
        got_err = 0;
        rst = 1'b1;
        base = n_out;
        feed(8'h9C, 1'b1);
        drain("post_reset_drain");
        chk(n_out == base, "post_reset_no_output", n_out - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
